// File: rtl/arb_pkg.sv
// Shared types and constants for the N-requester arbiter.
package arb_pkg;

  // Arbiter FSM states: no owner, or exactly one owner holding the grant.
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Arbitration modes.
  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int unsigned arb_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Masked priority encoder: picks the first request at or above ptr (round
// robin, wrapping) or the lowest request (fixed), ignoring bits set in excl.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = arb_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] excl,
  input  logic               mode,
  output logic [ID_W-1:0]    winner,
  output logic               found
);

  logic [NUM_REQ-1:0] cand;
  logic [31:0]        start;
  logic [ID_W-1:0]    idx;

  assign cand  = req & ~excl;
  assign start = mode ? 32'(ptr) : 32'd0;

  // Walk candidates in priority order starting at 'start'; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((start + 32'(i)) % 32'(NUM_REQ));
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/arb_rr_fsm.sv
// N-requester grant FSM with fixed-priority or round-robin selection and
// bubble-free handover. Optional hold limit enabled by ARB_HOLD_LIMIT_EN:
// an owner is forced off after HOLD_MAX consecutive grant cycles when
// another requester is waiting.
module arb_rr_fsm
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MODE     = ARB_MODE_RR,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  output logic [NUM_REQ-1:0]                gnt,
  output logic                              gnt_valid,
  output logic [arb_id_width(NUM_REQ)-1:0]  gnt_id
);

  localparam int unsigned ID_W = arb_id_width(NUM_REQ);

  // Reject configurations the arbiter cannot implement.
  if (NUM_REQ < 1 || MODE > ARB_MODE_RR || HOLD_MAX < 2) begin : g_bad_param
    $error("arb_rr_fsm: need NUM_REQ>=1, MODE in {0,1}, HOLD_MAX>=2");
  end

  arb_state_t         state, state_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;

  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_ptr;
  logic               owner_req;
  logic               force_rel;
  logic               reselect;

  // The current owner is excluded from reselection; gnt is zero in IDLE.
  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .excl   (gnt),
    .mode   (MODE == ARB_MODE_RR),
    .winner (win_id),
    .found  (win_found)
  );

  // Masking with gnt keeps other (possibly unknown) req bits out of the hold path.
  assign owner_req = |(req & gnt);
  assign win_oh    = NUM_REQ'(1) << win_id;
  assign win_ptr   = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned       HOLD_W    = $clog2(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

  // Owner has used its window and someone else is waiting.
  assign force_rel = (hold_cnt == HOLD_LAST) && |(req & ~gnt);

  // Consecutive-grant counter for the current owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  assign reselect = !owner_req || force_rel;

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= |gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      ptr       <= ptr_nxt;
    end
  end

  // Next state: leave IDLE on any request, return only when nobody wants it.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (win_found) state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (reselect && !win_found) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Next outputs: grant, owner id, rr pointer and hold count.
  always_comb begin
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    ptr_nxt    = ptr;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_nxt = hold_cnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (win_found) begin
          gnt_nxt    = win_oh;
          gnt_id_nxt = win_id;
          ptr_nxt    = win_ptr;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (reselect) begin
          if (win_found) begin
            // Direct handover, no idle cycle in between.
            gnt_nxt    = win_oh;
            gnt_id_nxt = win_id;
            ptr_nxt    = win_ptr;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_nxt = '0;
`endif
          end else begin
            gnt_nxt    = '0;
            gnt_id_nxt = '0;
          end
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          // Saturate when nobody else is waiting.
          if (hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + HOLD_W'(1);
`endif
        end
      end
      default: begin
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
      end
    endcase
  end

endmodule

// File: doc/arb_rr_fsm.md
Name: arb_rr_fsm

Overview:
- N-requester arbiter FSM; successor to the 2-requester fixed-priority grant FSM.
- Generalised in requester count; selectable fixed-priority or round-robin mode.
- Back-to-back handover without an idle bubble.
- Sits between request sources (bus masters, DMA channels) and a single shared resource; grant holds while the owner keeps requesting.

Parameters:
- NUM_REQ, 4: number of requesters, ≥1.
- MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- HOLD_MAX, 16: max consecutive grant cycles before forced release; used only with ARB_HOLD_LIMIT_EN; ≥2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- req  input  NUM_REQ  request vector, level-sensitive, one bit per requester.
- gnt  output  NUM_REQ  registered one-hot grant, all-zero when idle.
- gnt_valid  output  1  registered; high when any gnt bit is set.
- gnt_id  output  max(1,$clog2(NUM_REQ))  registered binary index of owner; 0 when idle.

Behaviour:
- Reset (async, immediate, also mid-grant): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, rr pointer ptr=0, hold counter=0.
- All outputs registered. Grant appears the cycle after req is sampled (1-cycle latency); no combinational req->gnt path.
- States:
  - IDLE: no owner. If req != 0, select winner W, go to GRANT, drive gnt[W]=1, gnt_id=W. Else stay IDLE.
  - GRANT: owner O. If req[O]=1, keep the grant.
  - GRANT, req[O]=0 and other requests pending: pick a new winner from req and hand over next cycle (gnt switches directly O->W, no all-zero cycle).
  - GRANT, req[O]=0 and req=0: go to IDLE, gnt=0.
- Selection:
  - MODE=0: lowest set index of req.
  - MODE=1: first set bit at index ≥ ptr, searching upward and wrapping to 0.
  - On every new grant to W: ptr = (W+1) mod NUM_REQ. Wrap: W=NUM_REQ-1 gives ptr=0.
  - ptr is unused in MODE=0.
- Owner's own req bit is ignored during reselection at release, so the releasing requester cannot regain the grant in the handover cycle unless it is the only requester.
- NUM_REQ=1: degenerates to grant-follows-req with 1-cycle lag; gnt_id is constant 0.
- Glitch: a req pulse of one cycle in IDLE still yields a one-cycle grant. Release is seen one cycle later, so gnt drops on the following edge.
- X on req bits other than the owner's must not disturb gnt while the owner holds.

Optional Feature:
- Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - Hold counter increments each GRANT cycle with the same owner; clears on a new grant.
  - When counter = HOLD_MAX-1 and any other req bit is set, force release: the next cycle grants the selection over req excluding O (handover rules apply).
  - If no other request is pending, the owner keeps the grant and the counter saturates at HOLD_MAX-1.
- Undefined: no counter is synthesised; the owner holds indefinitely while requesting.

Decomposition:
- Package arb_pkg:
  - state typedef (ARB_IDLE, ARB_GRANT).
  - MODE constants ARB_MODE_FIXED=0, ARB_MODE_RR=1.
- One sub-module: arb_rr_pick.
  - Combinational masked priority encoder.
  - Inputs: req, ptr, excl mask, mode. Outputs: winner index, found flag.
  - Instantiated once in arb_rr_fsm.

Test Plan:
- Reset asserted mid-grant (gnt=0100) -> gnt=0, gnt_id=0, gnt_valid=0 immediately, without waiting for clk; ptr=0 after release.
- MODE=1, NUM_REQ=4, req=1111 held, each owner drops req for one cycle after its grant -> gnt sequence 0001,0010,0100,1000,0001 with no idle cycles.
- MODE=0, req=1010 -> gnt=0010. Owner drops (req=1000) -> next cycle gnt=1000. Then req=0000 -> gnt=0000, IDLE.
- MODE=1, ptr=3 (last grant to 2), req=0011 -> gnt=0001 (wrap search), ptr becomes 1.
- ARB_HOLD_LIMIT_EN, HOLD_MAX=4, req[0] held, req[2] raised at cycle 1 -> gnt[0] for exactly 4 cycles, then gnt=0100 with no gap.
- ARB_HOLD_LIMIT_EN, only req[1] held for 20 cycles -> gnt=0010 throughout, no release.
